// File: rtl/ipm2l_pkt_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ipm2l_pkt_fifo_pkg
// Purpose  : Shared types and constants for the packet FIFO with
//            first-word-fall-through output.
//            - Write-side FSM state encoding.
//            - Pointer-width constant and helper for parameterised depths.
// Revision : 1.0 - initial release
// ============================================================================
package ipm2l_pkt_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,   // between packets, nothing uncommitted
    IN_PKT  = 2'd1,   // at least one uncommitted word stored
    DISCARD = 2'd2    // packet overflowed; swallow beats until wr_last
  } wr_state_t;

  // Pointer width for the default depth (DEPTH_WIDTH = 9). Pointers carry one
  // extra bit so that full and empty can be told apart.
  localparam int DEPTH_WIDTH_DEF = 9;
  localparam int PTR_W           = DEPTH_WIDTH_DEF + 1;

  // Same rule for any other depth.
  function automatic int ptr_width(input int depth_width);
    return depth_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipm2l_pkt_fifo_wr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ipm2l_pkt_fifo_wr_ctrl
// Purpose  : Write-side control of the packet FIFO. Owns the speculative
//            write pointer (wp), the commit pointer (cp), the write FSM,
//            packet drop and overflow/discard handling.
// Ports    : clk, rst_n           - clock, async active-low reset
//            wr_en, wr_last       - write strobe and end-of-packet flag
//            wr_drop              - discard all uncommitted words
//            rp                   - read fetch pointer from the read side
//            wp, cp               - write and commit pointers
//            wr_full              - storage full (uncommitted words count)
//            wr_overflow          - registered one-cycle overflow pulse
//            mem_we               - write the current beat into memory at wp
//            commit               - a packet completed this cycle
// Revision : 1.0 - initial release
// ============================================================================
module ipm2l_pkt_fifo_wr_ctrl
  import ipm2l_pkt_fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_last,
  input  logic                 wr_drop,
  input  logic [DEPTH_WIDTH:0] rp,
  output logic [DEPTH_WIDTH:0] wp,
  output logic [DEPTH_WIDTH:0] cp,
  output logic                 wr_full,
  output logic                 wr_overflow,
  output logic                 mem_we,
  output logic                 commit
);

  localparam int c_PTR_W = ptr_width(DEPTH_WIDTH);
  localparam logic [c_PTR_W-1:0] c_DEPTH   = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};

  wr_state_t          r_state;
  wr_state_t          w_state_nxt;
  logic [c_PTR_W-1:0] r_wp;
  logic [c_PTR_W-1:0] r_cp;
  logic               r_overflow;
  logic [c_PTR_W-1:0] w_wp_nxt;
  logic [c_PTR_W-1:0] w_cp_nxt;
  logic               w_overflow_nxt;
  logic               w_mem_we;
  logic               w_commit;
  logic               w_full;

  // Full counts everything between the reader and the speculative pointer,
  // so an unfinished packet cannot be overrun.
  assign w_full = ((r_wp - rp) == c_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wp       <= '0;
      r_cp       <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wp       <= w_wp_nxt;
      r_cp       <= w_cp_nxt;
      r_overflow <= w_overflow_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wp_nxt       = r_wp;
    w_cp_nxt       = r_cp;
    w_overflow_nxt = 1'b0;
    w_mem_we       = 1'b0;
    w_commit       = 1'b0;

    if (wr_drop) begin
      // Drop wins over a same-cycle write; rewinding to cp is harmless when
      // nothing is uncommitted.
      w_wp_nxt    = r_cp;
      w_state_nxt = IDLE;
    end else if (r_state == DISCARD) begin
      // Beats are consumed regardless of wr_full; only wr_last matters.
      if (wr_en && wr_last) begin
        w_state_nxt = IDLE;
      end
    end else if (wr_en) begin
      if (w_full) begin
        // The partial packet can never complete: throw it away and skip the
        // remaining beats. A single-beat tail needs no discard phase.
        w_overflow_nxt = 1'b1;
        w_wp_nxt       = r_cp;
        w_state_nxt    = wr_last ? IDLE : DISCARD;
      end else begin
        w_mem_we = 1'b1;
        w_wp_nxt = r_wp + c_PTR_ONE;
        if (wr_last) begin
          w_cp_nxt    = r_wp + c_PTR_ONE;
          w_commit    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = IN_PKT;
        end
      end
    end
  end

  assign wp          = r_wp;
  assign cp          = r_cp;
  assign wr_full     = w_full;
  assign wr_overflow = r_overflow;
  assign mem_we      = w_mem_we;
  assign commit      = w_commit;

endmodule
`default_nettype wire

// File: rtl/ipm2l_pkt_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : ipm2l_pkt_fifo_fwft
// Purpose  : Single-clock packet FIFO with first-word-fall-through output.
//            The reader only sees committed packets; the writer may drop a
//            packet in progress; overflowing packets are discarded.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            wr_data, wr_en, wr_last    - write beat, strobe, end of packet
//            wr_drop                    - discard uncommitted words
//            wr_full, almost_full       - write-side flow control
//            wr_overflow                - pulse when a write is rejected
//            wr_water_level             - words stored incl. uncommitted
//            rd_data, rd_last, rd_valid - registered FWFT output
//            rd_ready                   - consumer accepts the current word
//            almost_empty               - read-side low-water flag
//            rd_water_level             - committed words incl. output reg
//            pkt_count                  - complete packets not fully read
// Revision : 1.0 - initial release
// ============================================================================
module ipm2l_pkt_fifo_fwft
  import ipm2l_pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH       = 64,
  parameter int DEPTH_WIDTH      = 9,
  parameter int ALMOST_FULL_NUM  = 508,
  parameter int ALMOST_EMPTY_NUM = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  output logic                  wr_full,
  output logic                  almost_full,
  output logic                  wr_overflow,
  output logic [DEPTH_WIDTH:0]  wr_water_level,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  rd_water_level,
  output logic [DEPTH_WIDTH:0]  pkt_count
);

  localparam int c_PTR_W = ptr_width(DEPTH_WIDTH);
  localparam int c_WORDS = 1 << DEPTH_WIDTH;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = {{DEPTH_WIDTH{1'b0}}, 1'b1};
  localparam logic [c_PTR_W-1:0] c_AF_NUM  = c_PTR_W'(ALMOST_FULL_NUM);
  localparam logic [c_PTR_W-1:0] c_AE_NUM  = c_PTR_W'(ALMOST_EMPTY_NUM);

  // Each entry holds {last, data}.
  logic [DATA_WIDTH:0]   r_mem [0:c_WORDS-1];

  logic [c_PTR_W-1:0]    w_wp;
  logic [c_PTR_W-1:0]    w_cp;
  logic [c_PTR_W-1:0]    r_rp;
  logic                  w_mem_we;
  logic                  w_commit;
  logic                  w_fetch;
  logic                  w_pop_last;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_last;
  logic                  r_rd_valid;
  logic [c_PTR_W-1:0]    r_pkt_count;
  logic [c_PTR_W-1:0]    w_wr_level;
  logic [c_PTR_W-1:0]    w_rd_level;

  ipm2l_pkt_fifo_wr_ctrl #(
    .DEPTH_WIDTH (DEPTH_WIDTH)
  ) u_wr_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_last     (wr_last),
    .wr_drop     (wr_drop),
    .rp          (r_rp),
    .wp          (w_wp),
    .cp          (w_cp),
    .wr_full     (wr_full),
    .wr_overflow (wr_overflow),
    .mem_we      (w_mem_we),
    .commit      (w_commit)
  );

  // Storage has no reset; contents are only ever read below cp.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_wp[DEPTH_WIDTH-1:0]] <= {wr_last, wr_data};
    end
  end

  // Refill the output register whenever it is empty or being consumed and a
  // committed word is waiting.
  assign w_fetch    = (w_cp != r_rp) && (!r_rd_valid || rd_ready);
  assign w_pop_last = r_rd_valid && rd_ready && r_rd_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rp       <= '0;
      r_rd_data  <= '0;
      r_rd_last  <= 1'b0;
      r_rd_valid <= 1'b0;
    end else if (w_fetch) begin
      {r_rd_last, r_rd_data} <= r_mem[r_rp[DEPTH_WIDTH-1:0]];
      r_rp       <= r_rp + c_PTR_ONE;
      r_rd_valid <= 1'b1;
    end else if (r_rd_valid && rd_ready) begin
      r_rd_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_count <= '0;
    end else begin
      case ({w_commit, w_pop_last})
        2'b10:   r_pkt_count <= r_pkt_count + c_PTR_ONE;
        2'b01:   r_pkt_count <= r_pkt_count - c_PTR_ONE;
        default: r_pkt_count <= r_pkt_count;
      endcase
    end
  end

  assign w_wr_level = w_wp - r_rp;
  // The word parked in the output register is still readable.
  assign w_rd_level = (w_cp - r_rp) + {{DEPTH_WIDTH{1'b0}}, r_rd_valid};

  assign wr_water_level = w_wr_level;
  assign rd_water_level = w_rd_level;
  assign almost_full    = (w_wr_level >= c_AF_NUM);
  assign almost_empty   = (w_rd_level <= c_AE_NUM);
  assign pkt_count      = r_pkt_count;
  assign rd_data        = r_rd_data;
  assign rd_last        = r_rd_last;
  assign rd_valid       = r_rd_valid;

endmodule
`default_nettype wire

// File: tb/tb_ipm2l_pkt_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module   : tb_ipm2l_pkt_fifo_fwft
// Purpose  : Directed self-checking bench for ipm2l_pkt_fifo_fwft with a
//            16-word configuration (DEPTH_WIDTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipm2l_pkt_fifo_fwft;

  localparam int DW  = 64;
  localparam int DPW = 4;

  logic           clk;
  logic           rst_n;
  logic [DW-1:0]  wr_data;
  logic           wr_en;
  logic           wr_last;
  logic           wr_drop;
  logic           wr_full;
  logic           almost_full;
  logic           wr_overflow;
  logic [DPW:0]   wr_water_level;
  logic [DW-1:0]  rd_data;
  logic           rd_last;
  logic           rd_valid;
  logic           rd_ready;
  logic           almost_empty;
  logic [DPW:0]   rd_water_level;
  logic [DPW:0]   pkt_count;

  int checks = 0;
  int errors = 0;
  int ovf_pulses;

  ipm2l_pkt_fifo_fwft #(
    .DATA_WIDTH       (DW),
    .DEPTH_WIDTH      (DPW),
    .ALMOST_FULL_NUM  (14),
    .ALMOST_EMPTY_NUM (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_last        (wr_last),
    .wr_drop        (wr_drop),
    .wr_full        (wr_full),
    .almost_full    (almost_full),
    .wr_overflow    (wr_overflow),
    .wr_water_level (wr_water_level),
    .rd_data        (rd_data),
    .rd_last        (rd_last),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .almost_empty   (almost_empty),
    .rd_water_level (rd_water_level),
    .pkt_count      (pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [DW-1:0] d, input logic last);
    wr_en   = 1'b1;
    wr_data = d;
    wr_last = last;
    tick();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_data  = '0;
    wr_en    = 1'b0;
    wr_last  = 1'b0;
    wr_drop  = 1'b0;
    rd_ready = 1'b1;
    #12;
    // ---------------- reset state ----------------
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_wr_overflow", wr_overflow, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_wr_level", wr_water_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- 3-word packet A ----------------
    wr(64'hA0, 1'b0);
    wr(64'hA1, 1'b0);
    wr(64'hA2, 1'b1);
    chk("a_commit_no_valid_yet", rd_valid, 0);
    chk("a_pkt_count_1", pkt_count, 1);
    chk("a_wr_level_3", wr_water_level, 3);
    tick();
    chk("a_valid_after_1", rd_valid, 1);
    chk("a_data0", rd_data, 64'hA0);
    chk("a_last0", rd_last, 0);
    chk("a_almost_empty", almost_empty, 1);
    chk("a_rd_level_3", rd_water_level, 3);
    tick();
    chk("a_data1", rd_data, 64'hA1);
    chk("a_valid1", rd_valid, 1);
    tick();
    chk("a_data2", rd_data, 64'hA2);
    chk("a_last2", rd_last, 1);
    chk("a_pkt_count_still_1", pkt_count, 1);
    tick();
    chk("a_drained_valid", rd_valid, 0);
    chk("a_pkt_count_0", pkt_count, 0);
    chk("a_almost_empty_end", almost_empty, 1);

    // ---------------- drop a partial packet, then B0 ----------------
    wr(64'hC0, 1'b0);
    wr(64'hC1, 1'b0);
    chk("drop_level_2", wr_water_level, 2);
    chk("drop_no_valid", rd_valid, 0);
    wr_drop = 1'b1;
    tick();
    wr_drop = 1'b0;
    chk("drop_level_0", wr_water_level, 0);
    wr(64'hB0, 1'b1);
    chk("b_level_1", wr_water_level, 1);
    tick();
    chk("b_valid", rd_valid, 1);
    chk("b_data", rd_data, 64'hB0);
    chk("b_last", rd_last, 1);
    tick();
    chk("b_drained", rd_valid, 0);

    // ---------------- write + drop in the same cycle ----------------
    wr(64'hD0, 1'b0);
    wr(64'hD1, 1'b0);
    wr_drop = 1'b1;
    wr(64'hD2, 1'b0);
    wr_drop = 1'b0;
    chk("wdrop_level_0", wr_water_level, 0);
    tick();
    tick();
    chk("wdrop_no_valid", rd_valid, 0);
    chk("wdrop_pkt_count", pkt_count, 0);

    // ---------------- 20-word packet overflows ----------------
    ovf_pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      wr(64'h100 + 64'(i), (i == 20));
      if (wr_overflow) ovf_pulses++;
      if (i == 13) chk("ovf_af_13", almost_full, 0);
      if (i == 14) chk("ovf_af_14", almost_full, 1);
      if (i == 15) chk("ovf_full_15", wr_full, 0);
      if (i == 16) begin
        chk("ovf_full_16", wr_full, 1);
        chk("ovf_level_16", wr_water_level, 16);
      end
      if (i == 17) begin
        chk("ovf_pulse_17", wr_overflow, 1);
        chk("ovf_level_after", wr_water_level, 0);
      end
      if (i == 18) chk("ovf_pulse_gone_18", wr_overflow, 0);
    end
    chk("ovf_pulse_count", 64'(ovf_pulses), 1);
    tick();
    chk("ovf_empty_level", wr_water_level, 0);
    chk("ovf_no_valid", rd_valid, 0);
    chk("ovf_pkt_count", pkt_count, 0);
    wr(64'hE0, 1'b0);
    wr(64'hE1, 1'b1);
    tick();
    chk("e_data0", rd_data, 64'hE0);
    chk("e_last0", rd_last, 0);
    tick();
    chk("e_data1", rd_data, 64'hE1);
    chk("e_last1", rd_last, 1);
    tick();
    chk("e_drained", rd_valid, 0);

    // ---------------- backpressure with 4 one-word packets ----------------
    rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(64'hF0 + 64'(i), 1'b1);
    chk("bp_pkt_count_4", pkt_count, 4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", rd_data, 64'hF0);
    end
    chk("bp_hold_valid", rd_valid, 1);
    chk("bp_rd_level_4", rd_water_level, 4);
    chk("bp_almost_empty", almost_empty, 1);
    rd_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("bp_drain_data", rd_data, 64'hF0 + 64'(k));
      chk("bp_drain_pkt_count", pkt_count, 64'(4 - k));
    end
    tick();
    chk("bp_drained_valid", rd_valid, 0);
    chk("bp_drained_pkt_count", pkt_count, 0);

    // ---------------- fill to full, free one slot, write again ----------------
    rd_ready = 1'b0;
    for (int i = 0; i < 17; i++) wr(64'h200 + 64'(i), 1'b1);
    chk("full_flag", wr_full, 1);
    chk("full_wr_level", wr_water_level, 16);
    chk("full_rd_level", rd_water_level, 17);
    chk("full_pkt_count", pkt_count, 17);
    chk("full_almost_full", almost_full, 1);
    chk("full_almost_empty", almost_empty, 0);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("free_full_clear", wr_full, 0);
    chk("free_data", rd_data, 64'h201);
    chk("free_pkt_count", pkt_count, 16);
    wr(64'h2FF, 1'b1);
    chk("refill_full", wr_full, 1);
    chk("refill_no_overflow", wr_overflow, 0);
    chk("refill_pkt_count", pkt_count, 17);
    rd_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      chk("full_drain_valid", rd_valid, 1);
      chk("full_drain_data", rd_data, (k < 16) ? 64'h201 + 64'(k) : 64'h2FF);
      chk("full_drain_last", rd_last, 1);
      tick();
    end
    chk("full_drained", rd_valid, 0);
    chk("full_drained_pc", pkt_count, 0);

    // ---------------- packet straddling the pointer wrap ----------------
    for (int i = 0; i < 8; i++) begin
      wr(64'h300 + 64'(i), (i == 7));
      if (i == 6) chk("wrap_level_7", wr_water_level, 7);
    end
    chk("wrap_level_8", wr_water_level, 8);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("wrap_data", rd_data, 64'h300 + 64'(k));
      chk("wrap_last", rd_last, (k == 7) ? 1 : 0);
    end
    tick();
    chk("wrap_drained", rd_valid, 0);
    chk("wrap_level_0", wr_water_level, 0);

    // ---------------- asynchronous reset mid-packet ----------------
    wr(64'h400, 1'b0);
    wr(64'h401, 1'b0);
    chk("arst_pre_level", wr_water_level, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_level_0", wr_water_level, 0);
    chk("arst_almost_empty", almost_empty, 1);
    chk("arst_rd_valid", rd_valid, 0);
    tick();
    rst_n = 1'b1;
    wr(64'h500, 1'b1);
    tick();
    chk("post_rst_data", rd_data, 64'h500);
    chk("post_rst_valid", rd_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
